// File: rtl/dec_rf_pkg.sv
// Shared sizes and types for the decode-stage register file and scoreboard.
package dec_rf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int PEND_W     = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [PEND_W-1:0]     pend_cnt_t;

    // Saturated pending count: no further writes to this register may issue.
    localparam pend_cnt_t PEND_MAX = '1;

endpackage : dec_rf_pkg

// File: rtl/wrb_dec_pkg.sv
// Writeback-to-decode port packet: one register write per valid cycle.
package wrb_dec_pkg;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wrb_dec_pkt_t;

endpackage : wrb_dec_pkg

// File: rtl/dec_rf_scoreboard.sv
// Per-register in-flight write tracking and issue hazard evaluation.
// With REGFILE_BYPASS_EN defined, a source whose last pending write retires
// in the current cycle is considered ready (the data is forwarded by the
// register file in the same cycle).
module dec_rf_scoreboard
    import dec_rf_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      wrb_vld,
    input  reg_addr_t wrb_addr,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    input  logic      rs_use,
    input  logic      rt_use,
    input  logic      iss_vld,
    input  logic      iss_dst_vld,
    input  reg_addr_t iss_dst_reg,
    output logic      dec_stall,
    output logic      sb_err
);

    pend_cnt_t pend_q [NUM_REGS];
    pend_cnt_t pend_d [NUM_REGS];
    logic      sb_err_q;
    logic      sb_err_d;

    logic      wrb_hit;
    logic      rs_retire;
    logic      rt_retire;
    pend_cnt_t rs_pend_eff;
    pend_cnt_t rt_pend_eff;
    logic      rs_haz;
    logic      rt_haz;
    logic      dst_haz;
    logic      issue_fire;

    // Hazard evaluation against current pending counts.
    always_comb begin
        wrb_hit = wrb_vld && (wrb_addr != '0);
`ifdef REGFILE_BYPASS_EN
        rs_retire = wrb_hit && (wrb_addr == rs_addr) && (pend_q[rs_addr] != '0);
        rt_retire = wrb_hit && (wrb_addr == rt_addr) && (pend_q[rt_addr] != '0);
`else
        rs_retire = 1'b0;
        rt_retire = 1'b0;
`endif
        rs_pend_eff = pend_q[rs_addr] - pend_cnt_t'(rs_retire);
        rt_pend_eff = pend_q[rt_addr] - pend_cnt_t'(rt_retire);
        rs_haz      = rs_use && (rs_addr != '0) && (rs_pend_eff != '0);
        rt_haz      = rt_use && (rt_addr != '0) && (rt_pend_eff != '0);
        // Saturation check uses the raw count: a retiring write does not
        // make room for a new one in the same cycle.
        dst_haz     = iss_dst_vld && (iss_dst_reg != '0) &&
                      (pend_q[iss_dst_reg] == PEND_MAX);
        dec_stall   = resetn && iss_vld && (rs_haz || rt_haz || dst_haz);
        issue_fire  = iss_vld && iss_dst_vld && !dec_stall && (iss_dst_reg != '0);
    end

    // Next pending counts: issue increments, writeback decrements, underflow flags.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r]
                      + pend_cnt_t'(issue_fire && (iss_dst_reg == reg_addr_t'(r)))
                      - pend_cnt_t'(wrb_hit && (wrb_addr == reg_addr_t'(r)) &&
                                    (pend_q[r] != '0));
            if (wrb_hit && (wrb_addr == reg_addr_t'(r)) && (pend_q[r] == '0)) begin
                sb_err_d = 1'b1;
            end
        end
    end

    // Pending counter array and sticky underflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule : dec_rf_scoreboard

// File: rtl/dec_regfile.sv
// Decode-stage register file: 32x32 array written by the writeback port,
// two combinational read ports, and the issue scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from the writeback
// packet to the read ports, paired with early hazard release in the scoreboard.
module dec_regfile
    import dec_rf_pkg::*;
    import wrb_dec_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         wrb_dec_vld,
    input  wrb_dec_pkt_t wrb_dec_pkt,
    input  reg_addr_t    rs_addr,
    input  reg_addr_t    rt_addr,
    input  logic         rs_use,
    input  logic         rt_use,
    output reg_data_t    rs_data,
    output reg_data_t    rt_data,
    input  logic         iss_vld,
    input  logic         iss_dst_vld,
    input  reg_addr_t    iss_dst_reg,
    output logic         dec_stall,
    output logic         sb_err
);

    reg_data_t regs_q [NUM_REGS];

    // Architectural register array; register 0 is never written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wrb_dec_vld && (wrb_dec_pkt.addr != '0)) begin
            regs_q[wrb_dec_pkt.addr] <= wrb_dec_pkt.data;
        end
    end

    // Read ports; optional forwarding of the in-flight writeback.
    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (resetn && wrb_dec_vld && (rs_addr != '0) && (wrb_dec_pkt.addr == rs_addr)) begin
            rs_data = wrb_dec_pkt.data;
        end
        if (resetn && wrb_dec_vld && (rt_addr != '0) && (wrb_dec_pkt.addr == rt_addr)) begin
            rt_data = wrb_dec_pkt.data;
        end
`endif
    end

    dec_rf_scoreboard u_sb (
        .clk         (clk),
        .resetn      (resetn),
        .wrb_vld     (wrb_dec_vld),
        .wrb_addr    (wrb_dec_pkt.addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_use      (rs_use),
        .rt_use      (rt_use),
        .iss_vld     (iss_vld),
        .iss_dst_vld (iss_dst_vld),
        .iss_dst_reg (iss_dst_reg),
        .dec_stall   (dec_stall),
        .sb_err      (sb_err)
    );

endmodule : dec_regfile

// File: doc/dec_regfile.md
Name: dec_regfile

Overview:
- Decode-stage register file and scoreboard; the receiving end of the writeback-to-decode port.
- Absorbs the writeback stage's valid/packet write stream into 32x32 architectural registers.
- Serves two combinational read ports to the decoder.
- Tracks in-flight destination writes per register and asserts a stall when a decoded instruction's sources or destination are unsafe.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- DATA_W, 32, register width.
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2**PEND_W-1.

Ports:
- clk  in  1  clock; single clock domain, all state rises on posedge clk.
- resetn  in  1  asynchronous active-low reset.
- wrb_dec_vld  in  1  writeback valid; packet is applied this cycle.
- wrb_dec_pkt  in  wrb_dec_pkg::wrb_dec_pkt_t  writeback packet: addr[4:0] destination register, data[DATA_W-1:0].
- rs_addr  in  5  read port A address.
- rt_addr  in  5  read port B address.
- rs_use  in  1  decoded instruction consumes rs.
- rt_use  in  1  decoded instruction consumes rt.
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- iss_vld  in  1  decoder wants to issue an instruction this cycle.
- iss_dst_vld  in  1  issuing instruction writes a register.
- iss_dst_reg  in  5  destination register of the issuing instruction.
- dec_stall  out  1  issue blocked this cycle; combinational.
- sb_err  out  1  sticky: writeback arrived for a register with zero pending count.

Behaviour:
- Reset (async, resetn=0):
  - all registers = 0; all pending counters = 0; sb_err = 0.
  - Outputs during reset: rs_data = rt_data = 0 and dec_stall = 0.
- Write:
  - On posedge with wrb_dec_vld=1 and addr!=0, reg[addr] <= data.
  - addr=0 writes are dropped; reg 0 always reads 0.
  - Write latency: 1 cycle to the array.
- Read:
  - rs_data = reg[rs_addr], rt_data = reg[rt_addr], combinational; address 0 returns 0.
- Pending counters, pend[r]:
  - Increment when iss_vld & iss_dst_vld & !dec_stall & iss_dst_reg!=0 & iss_dst_reg==r.
  - Decrement when wrb_dec_vld & wrb_dec_pkt.addr==r & r!=0 & pend[r]!=0.
  - Both in the same cycle on the same register: net unchanged.
  - Decrement requested with pend[r]==0: counter stays 0 and sb_err <= 1. sb_err clears only on reset.
- Source hazard: src_haz(x) = x_use & x_addr!=0 & pend_eff[x_addr]!=0.
  - pend_eff = pend[r] minus 1 when this cycle's writeback targets r (with REGFILE_BYPASS_EN); otherwise pend[r].
- Destination hazard: dst_haz = iss_dst_vld & iss_dst_reg!=0 & pend[iss_dst_reg]==2**PEND_W-1 (counter saturated).
- dec_stall = iss_vld & (src_haz(rs) | src_haz(rt) | dst_haz).
- dec_stall=0 whenever iss_vld=0.
- A stalled issue changes no state. The decoder must hold its inputs stable until dec_stall=0.
- Mid-operation reset clears all pending state immediately. Writebacks arriving after reset for pre-reset issues set sb_err; upstream flushes on reset, so this is a legal error indication.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-through. If wrb_dec_vld and wrb_dec_pkt.addr==rs_addr (nonzero), rs_data = wrb_dec_pkt.data; likewise rt.
  - pend_eff subtracts the retiring write, so a source whose last pending write retires this cycle does not stall.
- Undefined:
  - Reads see only array contents.
  - Source hazard uses raw pend, so the instruction stalls one extra cycle and reads the value after it is written.

Decomposition:
- Package dec_rf_pkg:
  - NUM_REGS, REG_ADDR_W=5, DATA_W.
  - reg_addr_t, reg_data_t.
  - pend_cnt_t, PEND_MAX.
- wrb_dec_pkg::wrb_dec_pkt_t is reused unchanged.
- Sub-module dec_rf_scoreboard:
  - Holds the pending counter array, the inc/dec/underflow logic, sb_err, and hazard evaluation.
  - Outputs dec_stall.
  - dec_regfile keeps the data array, read muxing and bypass.

Test Plan:
- Reset then read: rs_addr=5, rt_addr=0 -> rs_data=0, rt_data=0; dec_stall=0; sb_err=0.
- Write then read: wrb_dec_vld=1, addr=3, data=0xDEADBEEF; next cycle rs_addr=3 -> rs_data=0xDEADBEEF. Write addr=0, data=0x1 -> reading reg 0 returns 0.
- RAW stall:
  - Issue dst=7 (stall 0). Next cycle issue with rs_addr=7, rs_use=1 -> dec_stall=1.
  - Writeback addr=7 arrives: with REGFILE_BYPASS_EN, dec_stall=0 that cycle and rs_data=wb data; without it, dec_stall=0 the following cycle.
- Saturation: three issues to dst=9 with no writeback -> pend=3. Fourth issue to dst=9 -> dec_stall=1. A writeback to 9 in the same cycle does not release it, because dst_haz uses raw pend. Next cycle dec_stall=0 and pend returns to 3.
- Simultaneous inc/dec: pend[4]=1; issue dst=4 and writeback addr=4 in the same cycle -> pend[4] stays 1; sb_err=0.
- Underflow and reset:
  - Writeback addr=12 with pend[12]=0 -> sb_err=1 and stays 1.
  - Assert resetn=0 mid-stream -> sb_err=0, all pend=0, regs=0 immediately.
